// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: parameter defaults,
// the arbiter state encoding and an index-width helper.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUFFER_WIDTH = 16;
  localparam int DEF_PAR_WRITE    = 4;
  localparam int DEF_MAX_BURST    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Keeps index vectors at least one bit wide when a count is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter in one bundle.
// The master modport is the environment; the slave modport is the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int PAR_WRITE    = DEF_PAR_WRITE
) ();

  localparam int ID_W = idx_width(NUM_REQ);
  localparam int DW   = PAR_WRITE * BUFFER_WIDTH;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_buffer_ready;
  logic                  fifo_wen;
  logic [DW-1:0]         fifo_din;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_last, req_data, fifo_buffer_ready,
    input  req_ready, fifo_wen, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_buffer_ready,
    output req_ready, fifo_wen, fifo_din, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester strictly after
// last_grant, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_valid
);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick_id    = idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of FIFO
// write beats, ending on req_last or after MAX_BURST transfers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int PAR_WRITE    = DEF_PAR_WRITE,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input logic               clk,
  input logic               rstn,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W  = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(MAX_BURST);
  localparam int DW    = PAR_WRITE * BUFFER_WIDTH;

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] grant_id_q, grant_id_nxt;
  logic [ID_W-1:0] last_grant_q, last_grant_nxt;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_nxt;

  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               wen;
  logic [DW-1:0]      din;
  logic [NUM_REQ-1:0] ready_vec;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // last_grant resets to the top index so requester 0 wins the first pick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state        <= state_nxt;
      grant_id_q   <= grant_id_nxt;
      last_grant_q <= last_grant_nxt;
      beat_cnt_q   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_id_nxt   = grant_id_q;
    last_grant_nxt = last_grant_q;
    beat_cnt_nxt   = beat_cnt_q;
    wen            = 1'b0;
    din            = '0;
    ready_vec      = '0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_id_nxt = pick_id;
          state_nxt    = GRANT;
        end
      end

      GRANT: begin
        din                   = bus.req_data[int'(grant_id_q)*DW +: DW];
        ready_vec[grant_id_q] = bus.fifo_buffer_ready;
        wen                   = bus.req_valid[grant_id_q] & bus.fifo_buffer_ready;
        // A dropped valid or a stalled FIFO simply holds the grant.
        if (wen) begin
          if (bus.req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_nxt      = IDLE;
            beat_cnt_nxt   = '0;
            last_grant_nxt = grant_id_q;
          end else begin
            beat_cnt_nxt = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fifo_wen  = wen;
  assign bus.fifo_din  = din;
  assign bus.req_ready = ready_vec;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int PW = 4;
  localparam int MB = 8;
  localparam int DW = PW * BW;
  localparam int VW = 1 + 2 + 1 + DW + N;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .BUFFER_WIDTH(BW), .PAR_WRITE(PW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ      (N),
    .BUFFER_WIDTH (BW),
    .PAR_WRITE    (PW),
    .MAX_BURST    (MB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner is -1 when no burst is granted.
  int m_owner = -1;
  int m_grant = 0;
  int m_last  = N - 1;
  int m_beats = 0;

  logic [VW-1:0] exp_vec, obs_vec;
  int            q_grant[$];
  int            q_xfer[$];
  logic [DW-1:0] q_din[$];
  logic          prev_busy = 1'b0;

  function automatic logic [VW-1:0] model_outputs();
    logic          e_busy, e_wen;
    logic [DW-1:0] e_din;
    logic [N-1:0]  e_rdy;
    e_busy = (m_owner >= 0);
    e_wen  = 1'b0;
    e_din  = '0;
    e_rdy  = '0;
    if (m_owner >= 0) begin
      e_wen          = bus.req_valid[m_owner] & bus.fifo_buffer_ready;
      e_din          = bus.req_data[m_owner*DW +: DW];
      e_rdy[m_owner] = bus.fifo_buffer_ready;
    end
    return {e_busy, 2'(m_grant), e_wen, e_din, e_rdy};
  endfunction

  task automatic model_update();
    if (!rstn) begin
      m_owner = -1;
      m_grant = 0;
      m_last  = N - 1;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (bus.req_valid[j]) begin
          m_grant = j;
          m_owner = j;
          break;
        end
      end
    end else if (bus.req_valid[m_owner] && bus.fifo_buffer_ready) begin
      m_beats++;
      if (bus.req_last[m_owner] || m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  // One clock: sample DUT and model away from the edge, then advance the model.
  task automatic cycle();
    @(negedge clk);
    exp_vec = model_outputs();
    obs_vec = {bus.busy, bus.grant_id, bus.fifo_wen, bus.fifo_din, bus.req_ready};
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) q_grant.push_back(int'(bus.grant_id));
    if (bus.fifo_wen === 1'b1) begin
      q_xfer.push_back(int'(bus.grant_id));
      q_din.push_back(bus.fifo_din);
    end
    prev_busy = bus.busy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N * DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    bus.req_valid         = v;
    bus.req_last          = l;
    bus.fifo_buffer_ready = r;
    bus.req_data          = rand_data();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    drive('0, '0, 1'b0);
    repeat (2) cycle();
    rstn = 1'b1;
    q_grant.delete();
    q_xfer.delete();
    q_din.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive('1, '1, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom));
      cycle();
      checks++;
      if (obs_vec !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h expected 0", obs_vec);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL reset_model: got %h expected %h", obs_vec, exp_vec);
      end
    end
    drive('0, '0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_single_burst();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive({3'b000, i < 4}, {3'b000, m_beats == 2}, 1'b1);
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL single_burst c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (q_xfer.size() != 3 || q_grant.size() != 1 || q_grant[0] != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_burst_summary: xfers %0d grants %0d busy %b, expected 3 xfers, 1 grant to 0, busy 0",
               q_xfer.size(), q_grant.size(), bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int           exp_order[5];
    logic [9:0]   busy_hist;
    exp_order = '{0, 1, 2, 3, 0};
    busy_hist = '0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive('1, '1, 1'b1);
      cycle();
      busy_hist = {busy_hist[8:0], obs_vec[VW-1]};
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL round_robin c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q_grant.size() <= i || q_grant[i] != exp_order[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d",
                 i, (q_grant.size() > i) ? q_grant[i] : -1, exp_order[i]);
      end
    end
    checks++;
    if (busy_hist !== 10'b0101010101) begin
      errors++;
      $display("[TB] FAIL rr_bubble: busy history %b expected 0101010101", busy_hist);
    end
  endtask

  task automatic test_max_burst();
    int n2;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive(4'b1100, 4'b0000, 1'b1);
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL max_burst c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    n2 = 0;
    foreach (q_xfer[i]) if (q_xfer[i] == 2) n2++;
    checks++;
    if (n2 != MB) begin
      errors++;
      $display("[TB] FAIL max_burst_count: got %0d transfers expected %0d", n2, MB);
    end
    checks++;
    if (q_grant.size() < 2 || q_grant[0] != 2 || q_grant[1] != 3) begin
      errors++;
      $display("[TB] FAIL max_burst_regrant: got %0d grants expected order 2 then 3", q_grant.size());
    end
  endtask

  task automatic test_stall();
    logic          rp[4];
    logic [5:0]    wen_hist;
    logic [DW-1:0] slice;
    rp       = '{1'b1, 1'b0, 1'b0, 1'b1};
    wen_hist = '0;
    slice    = {16'd4, 16'd3, 16'd2, 16'd1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive({2'b00, i < 5, 1'b0}, {2'b00, m_beats == 1, 1'b0}, (i >= 1 && i <= 4) ? rp[i-1] : 1'b1);
      bus.req_data[1*DW +: DW] = slice;
      cycle();
      wen_hist = {wen_hist[4:0], obs_vec[DW+N]};
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL stall c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (wen_hist !== 6'b010010) begin
      errors++;
      $display("[TB] FAIL stall_wen_pattern: got %b expected 010010", wen_hist);
    end
    checks++;
    if (q_din.size() != 2 || q_din[0] !== slice || q_din[1] !== slice) begin
      errors++;
      $display("[TB] FAIL stall_din: got %0d beats first %h expected 2 beats of %h",
               q_din.size(), (q_din.size() > 0) ? q_din[0] : '0, slice);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic        wen_after;
    logic [1:0]  gid_after;
    wen_after = 1'bx;
    gid_after = 2'bxx;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rstn = 1'b0;
      if (i == 3) begin
        rstn = 1'b1;
        q_grant.delete();
        q_xfer.delete();
        q_din.delete();
      end
      drive((i < 3) ? 4'b0100 : 4'b0101, {1'b0, m_beats == 4, 2'b00}, 1'b1);
      cycle();
      if (i == 3) begin
        wen_after = obs_vec[DW+N];
        gid_after = obs_vec[DW+N+2 +: 2];
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL reset_mid c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (wen_after !== 1'b0 || gid_after !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_abandon: wen %b grant %0d expected wen 0 grant 0", wen_after, gid_after);
    end
    checks++;
    if (q_grant.size() < 1 || q_grant[0] != 0 || q_xfer.size() < 1 || q_xfer[0] != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_first: grants %0d xfers %0d expected requester 0 served first",
               q_grant.size(), q_xfer.size());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 63) != 0);
      drive(N'($urandom) & N'($urandom), N'($urandom) & N'($urandom), $urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random c%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    drive('0, '0, 1'b0);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
